// File: rtl/irq_ctrl.sv
// irq_ctrl: memory-mapped edge/level interrupt controller with priority vector and registered irq.
// Optional software trigger via writes to VECTOR when IRQ_CTRL_SWTRIG_EN is defined.
module irq_ctrl #(
  parameter logic [7:0] BASE_ADDR   = 8'hA0,
  parameter logic [7:0] LAST_ADDR   = 8'hA3,
  parameter int         N_IRQ       = 4,
  parameter int         SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [7:0]       addr,
  input  logic [7:0]       dout,
  output logic [7:0]       din,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [N_IRQ-1:0] irq_src,
  output logic             irq
);
  logic [SYNC_STAGES-1:0][N_IRQ-1:0] r_sync;
  logic [N_IRQ-1:0] r_hist, r_pend, r_en, r_mode;
  logic             r_irq;
  logic [N_IRQ-1:0] w_synced, w_rise, w_pe, w_set, w_clr, w_w1c, w_ack, w_sw, w_l2e, w_pend_nxt;
  logic             w_sel, w_wr0, w_wr1, w_wr2, w_rd_vec, w_act;
  logic [2:0]       w_id;
  logic [7:0]       w_vec, w_rdata;
  logic             w_unused;

  assign w_sel    = (addr >= BASE_ADDR) && (addr <= LAST_ADDR);
  assign w_wr0    = wr_en && (addr == BASE_ADDR);
  assign w_wr1    = wr_en && (addr == BASE_ADDR + 8'd1);
  assign w_wr2    = wr_en && (addr == BASE_ADDR + 8'd2);
  assign w_rd_vec = rd_en && (addr == BASE_ADDR + 8'd3);
  assign w_unused = ^dout;

  assign w_synced = r_sync[SYNC_STAGES-1];
  assign w_rise   = w_synced & ~r_hist;
  assign w_pe     = r_pend & r_en;
  assign w_act    = |w_pe;

  always_comb begin
    w_id = '0;
    for (int i = N_IRQ - 1; i >= 0; i--)
      if (w_pe[i]) w_id = 3'(i);
  end

  assign w_vec   = {w_act, 4'b0, w_id};
  assign w_rdata = (addr == BASE_ADDR)        ? 8'(r_pend) :
                   (addr == BASE_ADDR + 8'd1) ? 8'(r_en)   :
                   (addr == BASE_ADDR + 8'd2) ? 8'(r_mode) : w_vec;
  assign din     = (rd_en && w_sel) ? w_rdata : 8'hzz;

`ifdef IRQ_CTRL_SWTRIG_EN
  logic w_wr3;
  assign w_wr3 = wr_en && (addr == BASE_ADDR + 8'd3);
  assign w_sw  = w_wr3 ? dout[N_IRQ-1:0] : '0;
`else
  assign w_sw  = '0;
`endif

  assign w_w1c = w_wr0 ? dout[N_IRQ-1:0] : '0;
  assign w_ack = (w_rd_vec && w_act) ? N_IRQ'(1) << w_id : '0;
  assign w_set = w_rise | w_sw;
  assign w_clr = w_w1c | w_ack;
  // Level-to-edge switch clears the bit; edge history already tracks synced, so no false edge.
  assign w_l2e = w_wr2 ? (~r_mode & dout[N_IRQ-1:0]) : '0;
  assign w_pend_nxt = ~w_l2e & ((r_mode & (w_set | (r_pend & ~w_clr))) | (~r_mode & w_synced));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
      r_hist <= '0;
      r_pend <= '0;
      r_en   <= '0;
      r_mode <= '0;
      r_irq  <= 1'b0;
    end else begin
      r_sync[0] <= irq_src;
      for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
      r_hist <= w_synced;
      r_pend <= w_pend_nxt;
      if (w_wr1) r_en <= dout[N_IRQ-1:0];
      if (w_wr2) r_mode <= dout[N_IRQ-1:0];
      r_irq <= |w_pe;
    end
  end

  assign irq = r_irq;
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed scoreboard bench for irq_ctrl; reads and irq probes queue expectations, a negedge monitor checks them.
module tb_irq_ctrl;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] addr = '0;
  logic [7:0] dout = '0;
  wire  [7:0] din;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic [3:0] irq_src = '0;
  logic       irq;
  logic       probe = 1'b0;
  int         checks = 0;
  int         failures = 0;

  typedef struct { logic [7:0] exp; bit hz; string nm; } rd_t;
  typedef struct { bit exp; string nm; } ir_t;
  rd_t q_rd[$];
  ir_t q_ir[$];
  rd_t e_rd;
  ir_t e_ir;

  irq_ctrl dut (
    .clk(clk), .reset_n(reset_n), .addr(addr), .dout(dout), .din(din),
    .wr_en(wr_en), .rd_en(rd_en), .irq_src(irq_src), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  always @(negedge clk) begin
    if (rd_en) begin
      if (q_rd.size() == 0) begin
        failures++;
        $display("FAIL rd_unexpected din=%h", din);
      end else begin
        e_rd = q_rd.pop_front();
        checks++;
        if (e_rd.hz ? !(din === 8'hzz || din === 8'h00) : (din !== e_rd.exp)) begin
          failures++;
          if (e_rd.hz) $display("FAIL %s din=%h exp=zz", e_rd.nm, din);
          else $display("FAIL %s din=%h exp=%h", e_rd.nm, din, e_rd.exp);
        end
      end
    end
    if (probe) begin
      if (q_ir.size() == 0) begin
        failures++;
        $display("FAIL irq_unexpected irq=%b", irq);
      end else begin
        e_ir = q_ir.pop_front();
        checks++;
        if (irq !== e_ir.exp) begin
          failures++;
          $display("FAIL %s irq=%b exp=%b", e_ir.nm, irq, e_ir.exp);
        end
      end
    end
  end

  task automatic op(input bit w, input bit r, input logic [7:0] a, input logic [7:0] d,
                    input logic [7:0] e, input bit hz, input bit ci, input bit ei, input string nm);
    rd_t t;
    ir_t u;
    addr = a; dout = d; wr_en = w; rd_en = r; probe = ci;
    if (r) begin t.exp = e; t.hz = hz; t.nm = nm; q_rd.push_back(t); end
    if (ci) begin u.exp = ei; u.nm = nm; q_ir.push_back(u); end
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0; probe = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    op(1, 0, a, d, 8'h00, 0, 0, 0, "wr");
  endtask
  task automatic rd(input logic [7:0] a, input logic [7:0] e, input string nm);
    op(0, 1, a, 8'h00, e, 0, 0, 0, nm);
  endtask
  task automatic rdi(input logic [7:0] a, input logic [7:0] e, input bit ei, input string nm);
    op(0, 1, a, 8'h00, e, 0, 1, ei, nm);
  endtask
  task automatic ck_irq(input bit ei, input string nm);
    op(0, 0, 8'h00, 8'h00, 8'h00, 0, 1, ei, nm);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) op(0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, "idle");
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    // Reset mid-traffic
    wr(8'hA1, 8'h01);
    wr(8'hA2, 8'h04);
    irq_src = 4'b0001;
    idle(3);
    ck_irq(0, "lvl_irq_latency");
    ck_irq(1, "lvl_irq_set");
    op(0, 1, 8'hA4, 8'h00, 8'h00, 1, 0, 0, "offaddr_hiz");
    rd(8'hA3, 8'h80, "lvl_vector");
    irq_src = 4'b0000;
    reset_n = 1'b0;
    ck_irq(0, "rst_irq_async");
    reset_n = 1'b1;
    rd(8'hA0, 8'h00, "rst_pending");
    rd(8'hA1, 8'h00, "rst_enable");
    rd(8'hA2, 8'h00, "rst_mode");
    ck_irq(0, "rst_irq");
    // Single edge source, acknowledge via VECTOR
    wr(8'hA1, 8'h04);
    wr(8'hA2, 8'h04);
    irq_src = 4'b0100;
    idle(3);
    irq_src = 4'b0000;
    rdi(8'hA0, 8'h04, 0, "edge_pend_e3");
    rdi(8'hA3, 8'h82, 1, "edge_vector");
    rd(8'hA0, 8'h00, "edge_acked");
    ck_irq(0, "edge_irq_drop");
    // Priority among two edge sources
    wr(8'hA1, 8'h0A);
    wr(8'hA2, 8'h0A);
    irq_src = 4'b1010;
    idle(3);
    irq_src = 4'b0000;
    rd(8'hA3, 8'h81, "prio_vec1");
    rd(8'hA3, 8'h83, "prio_vec3");
    rd(8'hA3, 8'h00, "prio_vec_none");
    // Level mode ignores W1C and follows the source
    wr(8'hA2, 8'h00);
    wr(8'hA1, 8'h01);
    irq_src = 4'b0001;
    idle(3);
    rd(8'hA0, 8'h01, "lvl_pend");
    wr(8'hA0, 8'h01);
    rd(8'hA0, 8'h01, "lvl_w1c_ignored");
    ck_irq(1, "lvl_irq");
    irq_src = 4'b0000;
    idle(3);
    rd(8'hA0, 8'h00, "lvl_fall");
    ck_irq(0, "lvl_irq_fall");
    // W1C coinciding with a new edge: set wins
    wr(8'hA2, 8'h04);
    wr(8'hA1, 8'h04);
    irq_src = 4'b0100;
    idle(2);
    wr(8'hA0, 8'h04);
    rd(8'hA0, 8'h04, "set_wins_w1c");
    irq_src = 4'b0000;
    wr(8'hA1, 8'h00);
    idle(1);
    ck_irq(0, "disable_irq");
    rd(8'hA0, 8'h04, "disable_keeps_pend");
    wr(8'hA0, 8'h04);
    rd(8'hA0, 8'h00, "w1c_clears");
    // Software trigger through VECTOR
    wr(8'hA2, 8'h08);
    wr(8'hA3, 8'h08);
`ifdef IRQ_CTRL_SWTRIG_EN
    rd(8'hA0, 8'h08, "swtrig");
`else
    rd(8'hA0, 8'h00, "swtrig_off");
`endif
    idle(2);
    checks++;
    if (q_rd.size() != 0 || q_ir.size() != 0) begin
      failures++;
      $display("FAIL queue_drain rd_left=%0d irq_left=%0d exp=0", q_rd.size(), q_ir.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
